// File: rtl/io_port_responder.sv
// io_port_responder: decodes IO port IDs for INPUT/OUTPUT instructions.
// Each output port has a FIFO that an external consumer drains.
// Each input port has a one-entry mailbox that an external producer fills.
// io_busy stalls the pipeline while a strobed access cannot complete.
// Optional feature: define IO_PORT_STATUS_EN to make ID 8'hFF a read-only
// status port.

module io_out_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr, r_rptr;
  logic [7:0]  r_mem [DEPTH];
  logic        w_pop, w_push;

  assign o_valid = (r_wptr != r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign w_pop   = o_valid && i_ready;
  assign w_push  = i_push && !o_full;

  // Pointers carry all FIFO state, so reset only needs to clear them
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage array; stale contents are harmless once pointers are equal
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

module io_port_responder #(
  parameter int NUM_OUT_PORTS = 4,
  parameter int NUM_IN_PORTS  = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [7:0]                 i_port_id,
  input  logic                       i_wr_strobe,
  input  logic [7:0]                 i_wr_data,
  input  logic                       i_rd_strobe,
  output logic                       o_io_busy,
  output logic [7:0]                 o_rd_data,
  output logic                       o_rd_valid,
  output logic                       o_err_unmapped,
  output logic [NUM_OUT_PORTS-1:0]   o_out_valid,
  output logic [8*NUM_OUT_PORTS-1:0] o_out_data,
  input  logic [NUM_OUT_PORTS-1:0]   i_out_ready,
  input  logic [NUM_IN_PORTS-1:0]    i_in_valid,
  input  logic [8*NUM_IN_PORTS-1:0]  i_in_data,
  output logic [NUM_IN_PORTS-1:0]    o_in_ready
);
  logic [NUM_OUT_PORTS-1:0]     w_wr_sel, w_fifo_full, w_push;
  logic [NUM_IN_PORTS-1:0]      w_rd_sel, w_cap, w_avail, w_pop_mb;
  logic [NUM_IN_PORTS-1:0]      r_mb_full, r_mb_hold;
  logic [NUM_IN_PORTS-1:0][7:0] r_mb_data;
  logic                         w_wr_block, w_rd_block, w_wr_acc, w_rd_acc;
  logic                         w_status_sel, w_unmapped;
  logic [7:0]                   w_rd_mux;
  logic [7:0]                   r_rd_data;
  logic                         r_rd_valid, r_err;

  for (genvar p = 0; p < NUM_OUT_PORTS; p++) begin : g_out
    assign w_wr_sel[p] = (i_port_id == 8'(p));
    assign w_push[p]   = w_wr_acc && w_wr_sel[p];
    io_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push[p]),
      .i_data  (i_wr_data),
      .i_ready (i_out_ready[p]),
      .o_valid (o_out_valid[p]),
      .o_data  (o_out_data[p*8 +: 8]),
      .o_full  (w_fifo_full[p])
    );
  end

  // A mailbox counts as readable when full or when it captures this edge,
  // so a stalled INPUT completes on the same edge the producer delivers.
  for (genvar p = 0; p < NUM_IN_PORTS; p++) begin : g_in
    assign w_rd_sel[p]   = (i_port_id == 8'(p));
    assign o_in_ready[p] = !r_mb_full[p] && !r_mb_hold[p];
    assign w_cap[p]      = i_in_valid[p] && o_in_ready[p];
    assign w_avail[p]    = r_mb_full[p] || w_cap[p];
    assign w_pop_mb[p]   = w_rd_acc && w_rd_sel[p];
  end

`ifdef IO_PORT_STATUS_EN
  localparam logic [7:0] STATUS_ID = 8'hFF;
  logic [7:0] w_status;
  assign w_status_sel = (i_port_id == STATUS_ID);
  for (genvar i = 0; i < 4; i++) begin : g_stat
    if (i < NUM_OUT_PORTS) begin : g_o
      assign w_status[4+i] = w_fifo_full[i];
    end else begin : g_o0
      assign w_status[4+i] = 1'b0;
    end
    if (i < NUM_IN_PORTS) begin : g_i
      assign w_status[i] = r_mb_full[i];
    end else begin : g_i0
      assign w_status[i] = 1'b0;
    end
  end
`else
  assign w_status_sel = 1'b0;
`endif

  // Stall on full FIFO (write) or empty mailbox (read); a pop in the same
  // cycle does not release a full FIFO, keeping busy off the ready path.
  assign w_wr_block = i_wr_strobe && |(w_wr_sel & w_fifo_full);
  assign w_rd_block = i_rd_strobe && |(w_rd_sel & ~w_avail);
  assign o_io_busy  = w_wr_block || w_rd_block;
  assign w_wr_acc   = i_wr_strobe && !o_io_busy;
  assign w_rd_acc   = i_rd_strobe && !o_io_busy;
  assign w_unmapped = !w_status_sel &&
                      ((w_wr_acc && !(|w_wr_sel)) || (w_rd_acc && !(|w_rd_sel)));

  // Read data source: mailbox, bypassed producer data, status, or zero
  always_comb begin
    w_rd_mux = 8'h00;
    for (int p = 0; p < NUM_IN_PORTS; p++) begin
      if (w_rd_sel[p]) w_rd_mux = r_mb_full[p] ? r_mb_data[p] : i_in_data[p*8 +: 8];
    end
`ifdef IO_PORT_STATUS_EN
    if (w_status_sel) w_rd_mux = w_status;
`endif
  end

  // Mailboxes. A bypassed read captures and consumes in one edge; the
  // mailbox then reports not-ready for one cycle, as if it had been full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mb_full <= '0;
      r_mb_hold <= '0;
      r_mb_data <= '0;
    end else begin
      for (int p = 0; p < NUM_IN_PORTS; p++) begin
        r_mb_hold[p] <= w_pop_mb[p] && !r_mb_full[p];
        if (w_pop_mb[p])   r_mb_full[p] <= 1'b0;
        else if (w_cap[p]) r_mb_full[p] <= 1'b1;
        if (w_cap[p])      r_mb_data[p] <= i_in_data[p*8 +: 8];
      end
    end
  end

  // INPUT result register, one-cycle valid pulse, sticky unmapped flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc)   r_rd_data <= w_rd_mux;
      if (w_unmapped) r_err     <= 1'b1;
    end
  end

  assign o_rd_data      = r_rd_data;
  assign o_rd_valid     = r_rd_valid;
  assign o_err_unmapped = r_err;
endmodule

// File: doc/io_port_responder.md
# io_port_responder

Peripheral-side responder for the processor's INPUT/OUTPUT instructions. EX resolves the 8-bit port ID, and MEMWB raises the read and write strobes. This block decodes the port ID and pushes OUTPUT data into per-port FIFOs drained by external consumers over valid/ready. It also holds one-entry input mailboxes filled by external producers and popped by INPUT. It applies backpressure to the pipeline through `io_busy`.

## Interface
- NUM_OUT_PORTS, 4, output ports, IDs 0..NUM_OUT_PORTS-1 (1..16)
- NUM_IN_PORTS, 4, input ports, IDs 0..NUM_IN_PORTS-1 (1..16)
- FIFO_DEPTH, 4, entries per output FIFO, power of two, ≥2

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- port_id  in  8  IO port ID from the pipeline
- wr_strobe  in  1  OUTPUT commit
- wr_data  in  8  OUTPUT data
- rd_strobe  in  1  INPUT request
- io_busy  out  1  combinational; the pipeline holds its strobe and ID while high
- rd_data  out  8  INPUT result, registered
- rd_valid  out  1  one-cycle qualifier for rd_data
- err_unmapped  out  1  sticky: an access hit an unmapped ID
- out_valid  out  NUM_OUT_PORTS  per-port FIFO non-empty
- out_data  out  8*NUM_OUT_PORTS  per-port FIFO head, port p at [p*8 +: 8]
- out_ready  in  NUM_OUT_PORTS  consumer accepts head
- in_valid  in  NUM_IN_PORTS  producer offers data
- in_data  in  8*NUM_IN_PORTS  producer data, port p at [p*8 +: 8]
- in_ready  out  NUM_IN_PORTS  mailbox empty

## Operation
- Reset values: all FIFOs empty, all mailboxes empty, rd_data=8'h00, rd_valid=0, err_unmapped=0. The combinational outputs follow from that state: out_valid=0, in_ready=all 1s, io_busy=0.
- Write blocking: `wr_strobe` with a mapped ID whose FIFO is full raises `io_busy`.
- Read blocking: `rd_strobe` with a mapped ID whose mailbox is empty raises `io_busy`.
- `io_busy` is the OR of the write and read block conditions.
- Accept rule: when `io_busy`=0, every asserted strobe is accepted at that edge. When `io_busy`=1, neither strobe is accepted.
- Accepted write to a mapped ID: push `wr_data` at the tail.
- Accepted read to a mapped ID: copy the mailbox into `rd_data`, set `rd_valid`, and empty the mailbox.
- Unmapped write: dropped. Unmapped read: returns 8'h00 with `rd_valid`=1. Either sets `err_unmapped`, which clears only on reset.
- Out FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers; pointers wrap modulo 2·FIFO_DEPTH.
  - Full when the index bits are equal and the MSBs differ; empty when the pointers are equal.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle on a non-full FIFO: both occur and the count is unchanged.
  - A push to a full FIFO is refused even if a pop occurs that cycle, because `io_busy` is computed from full alone.
- Mailbox:
  - Capture on in_valid && in_ready; `in_ready` = !full.
  - A mailbox popped by INPUT in cycle N can capture again at the earliest in cycle N+1.

## Timing
- Write latency: accepted at edge N → out_valid/out_data visible after edge N.
- Read latency: accepted at edge N → rd_valid high for exactly cycle N+1. rd_data holds its value until the next accepted read.
- Capture: captured at edge N → in_ready low after N, and a read is accepted at N if its strobe is present then.
- io_busy is combinational from strobes, port_id and full/empty state; no registered delay.
- Reset asserted mid-transfer: FIFO contents are discarded and rd_valid is forced low asynchronously. Operation resumes on the first edge after release.

## Configuration
- `IO_PORT_STATUS_EN` defined: port ID 8'hFF is a read-only status port.
  - A read never blocks and returns {out-FIFO-full[3:0], mailbox-full[3:0]} for ports 0–3, with absent ports reading 0.
  - A write to 8'hFF is dropped without setting err_unmapped.
- Undefined: 8'hFF is an ordinary unmapped ID.

## Test plan
- Reset low mid-stream with 2 entries queued on port 1 → out_valid=0, in_ready=4'hF, rd_valid=0, err_unmapped=0 immediately.
- Write 8'hA1, 8'hA2, 8'hA3, 8'hA4 to port 2 with out_ready=0, then write 8'hA5 → io_busy=1 on the fifth write. Pulse out_ready for one cycle → 8'hA1 is popped. The next cycle 8'hA5 is accepted, and the FIFO drains A2, A3, A4, A5 in order.
- Continuous writes and out_ready=1 on port 0 across 10 words → order preserved through pointer wrap, no loss, io_busy never set.
- rd_strobe on empty port 3 → io_busy=1. Drive in_valid with 8'h5C → the read is accepted that edge and rd_data=8'h5C, rd_valid=1 the next cycle; in_ready returns to 1 the cycle after.
- Write to port 8'h40 and read from 8'h41 with defaults → write dropped, rd_data=8'h00 with rd_valid, err_unmapped=1 and sticky.
- With IO_PORT_STATUS_EN: port 0 FIFO full and mailbox 2 full, read 8'hFF → rd_data=8'h14.
